buble_pipe: RTL and testbench
=============================

BUBLE_PIPE -- requirements
Module: buble_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages between input and output (>=1).
REQ-003 SHALL have parameter SKID, default 0: 0 = bubble-collapsing stages with combinational ready chain; 1 = skid stages with registered ready.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-006 SHALL have port flush  input  1  synchronous clear of all held entries.
REQ-007 SHALL have port data_a  input  WIDTH  upstream payload.
REQ-008 SHALL have port vld_a  input  1  upstream valid.
REQ-009 SHALL have port rdy_a  output  1  ready to upstream; transfer when vld_a && rdy_a at rising clk.
REQ-010 SHALL have port data_b  output  WIDTH  downstream payload.
REQ-011 SHALL have port vld_b  output  1  downstream valid.
REQ-012 SHALL have port rdy_b  input  1  downstream ready; transfer when vld_b && rdy_b at rising clk.
REQ-013 SHALL have port occ  output  $clog2(DEPTH*(1+SKID)+1)  registered count of entries held.

Function
REQ-014 SHALL deliver every accepted word exactly once, in acceptance order; no drop, no duplicate.
REQ-015 SHALL implement stages 0..DEPTH-1; stage 0 fed from data_a, stage DEPTH-1 drives data_b/vld_b.
REQ-016 SKID=0: stage i ready = !valid[i] || ready[i+1], ready[DEPTH] = rdy_b; rdy_a = ready[0] (combinational path from rdy_b permitted).
REQ-017 SKID=0: a stage SHALL load when its ready is 1; it takes the upstream stage's valid/data (bubbles collapse; an empty stage always accepts).
REQ-018 SKID=1: each stage SHALL hold main + skid register; stage ready SHALL be a flop output equal to !skid_valid; rdy_a SHALL have no combinational path from rdy_b.
REQ-019 SKID=1: when main is full, not drained, and upstream word arrives, word SHALL go to skid; skid SHALL move to main in the cycle main drains; skid word precedes any newer word.
REQ-020 Latency SHALL be DEPTH cycles (accept at edge N -> vld_b high after edge N+DEPTH-1, i.e. available for transfer at edge N+DEPTH) with rdy_b held 1, both modes.
REQ-021 Throughput SHALL be one word per cycle with rdy_b held 1, both modes, no inserted bubbles.
REQ-022 data_b SHALL remain stable while vld_b && !rdy_b; vld_b SHALL not drop without a transfer except on flush/rst.
REQ-023 Capacity SHALL be DEPTH (SKID=0) or 2*DEPTH (SKID=1); rdy_a SHALL be 0 exactly when full (SKID=0) or stage-0 skid full (SKID=1).
REQ-024 Simultaneous accept and deliver in one cycle SHALL leave occ unchanged; occ SHALL never exceed capacity nor wrap below 0.
REQ-025 occ SHALL equal number of valid entries after each edge (+1 per accept, -1 per deliver).
REQ-026 flush=1: rdy_a SHALL be 0 and vld_b SHALL be 0 that cycle; at the edge all valid bits and occ SHALL clear; no transfer occurs in the flush cycle.
REQ-027 rst SHALL take priority over flush and all handshakes.

Reset
REQ-028 While rst=1 at an edge: all valid/skid-valid bits 0, all data registers 0, occ 0, stage-ready flops (SKID=1) 1.
REQ-029 After reset: vld_b=0, data_b=0, occ=0; rdy_a=1 in both modes.
REQ-030 Reset asserted mid-stream SHALL discard all held words; first word after release SHALL be the first accepted post-reset.

Verification
REQ-031 DEPTH=2,SKID=0, rdy_b=1, send 0x1..0x8 back-to-back -> out 0x1..0x8 in order, first vld_b 2 cycles after first accept, one per cycle.
REQ-032 DEPTH=3,SKID=1, rdy_b=0, vld_a=1 continuous -> exactly 6 accepted, rdy_a=0 thereafter, occ=6; release rdy_b -> 6 words out in order.
REQ-033 DEPTH=2 both modes, random vld_a and rdy_b toggling (period-irregular, ~30% low) for 1000 cycles -> scoreboard match, data_b stable while stalled.
REQ-034 Fill to occ=3 (DEPTH=4,SKID=0), assert flush one cycle with vld_a=1 -> next cycle occ=0, vld_b=0, flush-cycle word not delivered.
REQ-035 rst asserted with occ=2 and vld_b=1 -> next cycle vld_b=0, occ=0, data_b=0; post-reset word 0xA5 is first output.
REQ-036 SKID=1 check rdy_a changes only at clk edges with rdy_b toggled mid-cycle -> no combinational rdy_b->rdy_a dependence.

Source files
------------

// File: rtl/buble_pipe.sv
// Valid/ready register pipeline of DEPTH stages. SKID=0 collapses bubbles with a
// combinational ready chain; SKID=1 gives every stage a skid slot and a registered ready.
module buble_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int SKID  = 0,
  localparam int OCC_W = $clog2(DEPTH * (1 + SKID) + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_a,
  input  logic             vld_a,
  output logic             rdy_a,
  output logic [WIDTH-1:0] data_b,
  output logic             vld_b,
  input  logic             rdy_b,
  output logic [OCC_W-1:0] occ
);

  // Handshake: a word moves across a boundary on a rising edge where both valid
  // and ready are high; a valid producer holds its data until that edge.
  logic             main_vld [DEPTH];
  logic [WIDTH-1:0] main_dat [DEPTH];
  logic             in_vld   [DEPTH];
  logic [WIDTH-1:0] in_dat   [DEPTH];
  logic             accept;
  logic             deliver;

  always_comb begin
    in_vld[0] = vld_a;
    in_dat[0] = data_a;
    for (int i = 1; i < DEPTH; i++) begin
      in_vld[i] = main_vld[i-1];
      in_dat[i] = main_dat[i-1];
    end
  end

  assign vld_b   = main_vld[DEPTH-1] && !flush;
  assign data_b  = main_dat[DEPTH-1];
  assign accept  = vld_a && rdy_a;
  assign deliver = vld_b && rdy_b;

  if (SKID == 0) begin : g_bubble
    logic stg_rdy [DEPTH];
    logic chain;

    // A stage can load if it is empty or everything downstream of it moves.
    always_comb begin
      chain = rdy_b;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        chain      = !main_vld[i] || chain;
        stg_rdy[i] = chain;
      end
    end

    assign rdy_a = stg_rdy[0] && !flush;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          main_vld[i] <= 1'b0;
          main_dat[i] <= '0;
        end
      end else if (flush) begin
        for (int i = 0; i < DEPTH; i++) main_vld[i] <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (stg_rdy[i]) begin
            main_vld[i] <= in_vld[i];
            if (in_vld[i]) main_dat[i] <= in_dat[i];
          end
        end
      end
    end
  end else begin : g_skid
    logic             skid_vld [DEPTH];
    logic [WIDTH-1:0] skid_dat [DEPTH];
    logic             stg_rdy  [DEPTH];
    logic             ds_rdy   [DEPTH];

    always_comb begin
      ds_rdy[DEPTH-1] = rdy_b;
      for (int i = 0; i < DEPTH - 1; i++) ds_rdy[i] = stg_rdy[i+1];
    end

    assign rdy_a = stg_rdy[0] && !flush;

    // stg_rdy is kept equal to !skid_vld so no stage ready depends on downstream logic.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          main_vld[i] <= 1'b0;
          main_dat[i] <= '0;
          skid_vld[i] <= 1'b0;
          skid_dat[i] <= '0;
          stg_rdy[i]  <= 1'b1;
        end
      end else if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          main_vld[i] <= 1'b0;
          skid_vld[i] <= 1'b0;
          stg_rdy[i]  <= 1'b1;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (skid_vld[i]) begin
            if (ds_rdy[i]) begin
              main_dat[i] <= skid_dat[i];
              skid_vld[i] <= 1'b0;
              stg_rdy[i]  <= 1'b1;
            end
          end else if (!main_vld[i] || ds_rdy[i]) begin
            main_vld[i] <= in_vld[i];
            if (in_vld[i]) main_dat[i] <= in_dat[i];
          end else if (in_vld[i]) begin
            skid_vld[i] <= 1'b1;
            skid_dat[i] <= in_dat[i];
            stg_rdy[i]  <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) occ <= '0;
    else              occ <= occ + OCC_W'(accept) - OCC_W'(deliver);
  end

endmodule

// File: tb/tb_buble_pipe.sv
// Bench for buble_pipe: four instances (D2/S0, D3/S1, D4/S0, D2/S1) driven by a
// vector table, directed multi-cycle sequences and a random scoreboard run.
module tb_buble_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_v, flush_v, vld_a_v, rdy_b_v;
  wire  [3:0] rdy_a_v, vld_b_v;
  logic [7:0] data_a_v [4];
  wire  [7:0] data_b_v [4];
  wire  [1:0] occ0;
  wire  [2:0] occ1, occ2, occ3;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  buble_pipe #(.WIDTH(8), .DEPTH(2), .SKID(0)) u_a (
    .clk(clk), .rst(rst_v[0]), .flush(flush_v[0]), .data_a(data_a_v[0]), .vld_a(vld_a_v[0]),
    .rdy_a(rdy_a_v[0]), .data_b(data_b_v[0]), .vld_b(vld_b_v[0]), .rdy_b(rdy_b_v[0]), .occ(occ0));
  buble_pipe #(.WIDTH(8), .DEPTH(3), .SKID(1)) u_b (
    .clk(clk), .rst(rst_v[1]), .flush(flush_v[1]), .data_a(data_a_v[1]), .vld_a(vld_a_v[1]),
    .rdy_a(rdy_a_v[1]), .data_b(data_b_v[1]), .vld_b(vld_b_v[1]), .rdy_b(rdy_b_v[1]), .occ(occ1));
  buble_pipe #(.WIDTH(8), .DEPTH(4), .SKID(0)) u_c (
    .clk(clk), .rst(rst_v[2]), .flush(flush_v[2]), .data_a(data_a_v[2]), .vld_a(vld_a_v[2]),
    .rdy_a(rdy_a_v[2]), .data_b(data_b_v[2]), .vld_b(vld_b_v[2]), .rdy_b(rdy_b_v[2]), .occ(occ2));
  buble_pipe #(.WIDTH(8), .DEPTH(2), .SKID(1)) u_d (
    .clk(clk), .rst(rst_v[3]), .flush(flush_v[3]), .data_a(data_a_v[3]), .vld_a(vld_a_v[3]),
    .rdy_a(rdy_a_v[3]), .data_b(data_b_v[3]), .vld_b(vld_b_v[3]), .rdy_b(rdy_b_v[3]), .occ(occ3));

  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic       rdy_b;
    logic       flush;
    logic       e_rdy;
    logic       e_vld;
    logic [7:0] e_dat;
    logic       chk_dat;
    int         e_occ;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  function automatic vec_t mk(int v, int d, int rb, int fl, int er, int ev, int ed, int ck, int eo);
    vec_t r;
    r.vld = v[0]; r.dat = d[7:0]; r.rdy_b = rb[0]; r.flush = fl[0];
    r.e_rdy = er[0]; r.e_vld = ev[0]; r.e_dat = ed[7:0]; r.chk_dat = ck[0]; r.e_occ = eo;
    return r;
  endfunction

  function automatic logic [31:0] get_occ(input int idx);
    case (idx)
      0:       return 32'(occ0);
      1:       return 32'(occ1);
      2:       return 32'(occ2);
      default: return 32'(occ3);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s @%0t: got no event, expected one within bound", nm, $time);
  endtask

  task automatic clear(input int idx);
    vld_a_v[idx] = 1'b0;
    flush_v[idx] = 1'b1;
    tick();
    flush_v[idx] = 1'b0;
  endtask

  task automatic stream(input int idx, input int depth);
    for (int k = 0; k < 8 + depth; k++) begin
      vld_a_v[idx]  = (k < 8);
      data_a_v[idx] = 8'(k + 1);
      rdy_b_v[idx]  = 1'b1;
      #1;
      if (k < 8) chk("stream_rdy_a", 32'(rdy_a_v[idx]), 1);
      chk("stream_vld_b", 32'(vld_b_v[idx]), 32'(k >= depth));
      if (k >= depth) chk("stream_data_b", 32'(data_b_v[idx]), k - depth + 1);
      tick();
    end
    vld_a_v[idx] = 1'b0;
    #1;
    chk("stream_occ", get_occ(idx), 0);
  endtask

  task automatic run_random(input int idx, input int depth, input bit skid);
    logic [7:0] nxt;
    logic [7:0] held;
    logic       stall;
    logic       r0;
    int         cap;
    cap = skid ? 2 * depth : depth;
    exp_q.delete();
    nxt = 8'h01; held = '0; stall = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      vld_a_v[idx]  = ($urandom_range(0, 9) >= 3);
      data_a_v[idx] = nxt;
      rdy_b_v[idx]  = ($urandom_range(0, 9) >= 3);
      #1;
      if (skid) begin
        r0 = rdy_a_v[idx];
        rdy_b_v[idx] = !rdy_b_v[idx];
        #1;
        chk("rand_rdy_a_no_comb", 32'(rdy_a_v[idx]), 32'(r0));
        rdy_b_v[idx] = !rdy_b_v[idx];
        #1;
      end
      chk("rand_occ", get_occ(idx), exp_q.size());
      if (!skid) chk("rand_rdy_a", 32'(rdy_a_v[idx]), 32'((exp_q.size() < depth) || rdy_b_v[idx]));
      else if (exp_q.size() == cap) chk("rand_rdy_a_full", 32'(rdy_a_v[idx]), 0);
      if (stall) begin
        chk("rand_hold_vld", 32'(vld_b_v[idx]), 1);
        chk("rand_hold_data", 32'(data_b_v[idx]), 32'(held));
      end
      if (vld_b_v[idx] && rdy_b_v[idx]) begin
        if (exp_q.size() == 0) fail("rand_spurious_output");
        else chk("rand_data", 32'(data_b_v[idx]), 32'(exp_q.pop_front()));
      end
      if (vld_a_v[idx] && rdy_a_v[idx]) begin
        exp_q.push_back(nxt);
        nxt++;
      end
      stall = vld_b_v[idx] && !rdy_b_v[idx];
      held  = data_b_v[idx];
      tick();
    end
    vld_a_v[idx] = 1'b0;
    rdy_b_v[idx] = 1'b1;
    for (int c = 0; c < 4 * depth + 4 && exp_q.size() > 0; c++) begin
      #1;
      if (vld_b_v[idx]) chk("rand_drain_data", 32'(data_b_v[idx]), 32'(exp_q.pop_front()));
      tick();
    end
    if (exp_q.size() != 0) fail("rand_drain_timeout");
    #1;
    chk("rand_end_occ", get_occ(idx), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog @%0t: got no finish, expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    bit got;
    //            vld dat  rb fl  rdy vld edat ck occ
    tbl[0]  = mk(1, 'h01, 1, 0,  1, 0, 'h00, 0, 0);
    tbl[1]  = mk(1, 'h02, 1, 0,  1, 0, 'h00, 0, 1);
    tbl[2]  = mk(1, 'h03, 1, 0,  1, 1, 'h01, 1, 2);
    tbl[3]  = mk(1, 'h04, 1, 0,  1, 1, 'h02, 1, 2);
    tbl[4]  = mk(1, 'h05, 1, 0,  1, 1, 'h03, 1, 2);
    tbl[5]  = mk(1, 'h06, 1, 0,  1, 1, 'h04, 1, 2);
    tbl[6]  = mk(1, 'h07, 1, 0,  1, 1, 'h05, 1, 2);
    tbl[7]  = mk(1, 'h08, 1, 0,  1, 1, 'h06, 1, 2);
    tbl[8]  = mk(0, 'h00, 1, 0,  1, 1, 'h07, 1, 2);
    tbl[9]  = mk(0, 'h00, 1, 0,  1, 1, 'h08, 1, 1);
    tbl[10] = mk(1, 'h11, 0, 0,  1, 0, 'h00, 0, 0);
    tbl[11] = mk(1, 'h22, 0, 0,  1, 0, 'h00, 0, 1);
    tbl[12] = mk(1, 'h33, 0, 0,  0, 1, 'h11, 1, 2);
    tbl[13] = mk(1, 'h33, 1, 0,  1, 1, 'h11, 1, 2);
    tbl[14] = mk(0, 'h00, 0, 0,  0, 1, 'h22, 1, 2);
    tbl[15] = mk(0, 'h00, 1, 0,  1, 1, 'h22, 1, 2);
    tbl[16] = mk(0, 'h00, 0, 0,  1, 1, 'h33, 1, 1);
    tbl[17] = mk(1, 'h44, 0, 1,  0, 0, 'h00, 0, 1);
    tbl[18] = mk(0, 'h00, 1, 0,  1, 0, 'h00, 0, 0);
    tbl[19] = mk(1, 'h55, 0, 0,  1, 0, 'h00, 0, 0);
    tbl[20] = mk(0, 'h00, 0, 0,  1, 0, 'h00, 0, 1);
    tbl[21] = mk(1, 'h66, 0, 0,  1, 1, 'h55, 1, 1);
    tbl[22] = mk(1, 'h77, 0, 0,  0, 1, 'h55, 1, 2);
    tbl[23] = mk(0, 'h00, 1, 0,  1, 1, 'h55, 1, 2);
    tbl[24] = mk(0, 'h00, 1, 0,  1, 1, 'h66, 1, 1);
    tbl[25] = mk(0, 'h00, 1, 0,  1, 0, 'h00, 0, 0);

    rst_v = '1; flush_v = '0; vld_a_v = '0; rdy_b_v = '0;
    for (int i = 0; i < 4; i++) data_a_v[i] = '0;
    tick();
    tick();
    rst_v = '0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_vld_b", 32'(vld_b_v[i]), 0);
      chk("rst_data_b", 32'(data_b_v[i]), 0);
      chk("rst_occ", get_occ(i), 0);
      chk("rst_rdy_a", 32'(rdy_a_v[i]), 1);
    end

    // D2/S0: streaming, stalls, flush and bubble collapse from the table
    for (int k = 0; k < NV; k++) begin
      vld_a_v[0] = tbl[k].vld; data_a_v[0] = tbl[k].dat;
      rdy_b_v[0] = tbl[k].rdy_b; flush_v[0] = tbl[k].flush;
      #1;
      chk($sformatf("tbl%0d_rdy_a", k), 32'(rdy_a_v[0]), 32'(tbl[k].e_rdy));
      chk($sformatf("tbl%0d_vld_b", k), 32'(vld_b_v[0]), 32'(tbl[k].e_vld));
      chk($sformatf("tbl%0d_occ", k), get_occ(0), tbl[k].e_occ);
      if (tbl[k].chk_dat) chk($sformatf("tbl%0d_data_b", k), 32'(data_b_v[0]), 32'(tbl[k].e_dat));
      tick();
    end
    flush_v[0] = 1'b0;

    // D2/S0: reset mid-stream
    vld_a_v[0] = 1'b1; data_a_v[0] = 8'h10; rdy_b_v[0] = 1'b0;
    tick();
    data_a_v[0] = 8'h20;
    tick();
    vld_a_v[0] = 1'b0;
    #1;
    chk("pre_rst_occ", get_occ(0), 2);
    chk("pre_rst_vld_b", 32'(vld_b_v[0]), 1);
    chk("pre_rst_data_b", 32'(data_b_v[0]), 'h10);
    rst_v[0] = 1'b1; vld_a_v[0] = 1'b1; data_a_v[0] = 8'hEE;
    tick();
    rst_v[0] = 1'b0; vld_a_v[0] = 1'b0;
    #1;
    chk("post_rst_vld_b", 32'(vld_b_v[0]), 0);
    chk("post_rst_occ", get_occ(0), 0);
    chk("post_rst_data_b", 32'(data_b_v[0]), 0);
    chk("post_rst_rdy_a", 32'(rdy_a_v[0]), 1);
    vld_a_v[0] = 1'b1; data_a_v[0] = 8'hA5; rdy_b_v[0] = 1'b1;
    tick();
    data_a_v[0] = 8'hB6;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      #1;
      if (vld_b_v[0]) begin
        got = 1'b1;
        chk("post_rst_first_word", 32'(data_b_v[0]), 'hA5);
      end else tick();
    end
    if (!got) fail("post_rst_first_word_timeout");
    clear(0);

    // D3/S1: throughput, fill with stalled output, registered ready, drain, latency
    stream(1, 3);
    exp_q.delete();
    acc = 0;
    rdy_b_v[1] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      vld_a_v[1] = 1'b1; data_a_v[1] = 8'(acc + 1);
      #1;
      if (rdy_a_v[1]) begin
        exp_q.push_back(8'(acc + 1));
        acc++;
      end
      tick();
    end
    vld_a_v[1] = 1'b0;
    #1;
    chk("skid_fill_accepted", acc, 6);
    chk("skid_fill_rdy_a", 32'(rdy_a_v[1]), 0);
    chk("skid_fill_occ", get_occ(1), 6);
    chk("skid_fill_vld_b", 32'(vld_b_v[1]), 1);
    chk("skid_fill_data_b", 32'(data_b_v[1]), 1);
    rdy_b_v[1] = 1'b1;
    #1;
    chk("skid_rdy_a_no_comb", 32'(rdy_a_v[1]), 0);
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      if (vld_b_v[1]) chk("skid_drain_data", 32'(data_b_v[1]), 32'(exp_q.pop_front()));
      tick();
      #1;
    end
    if (exp_q.size() != 0) fail("skid_drain_timeout");
    vld_a_v[1] = 1'b1; data_a_v[1] = 8'h5A; rdy_b_v[1] = 1'b1;
    #1;
    chk("skid_lat_rdy_a", 32'(rdy_a_v[1]), 1);
    tick();
    vld_a_v[1] = 1'b0;
    #1;
    chk("skid_lat_e0_vld_b", 32'(vld_b_v[1]), 0);
    tick(); #1;
    chk("skid_lat_e1_vld_b", 32'(vld_b_v[1]), 0);
    tick(); #1;
    chk("skid_lat_e2_vld_b", 32'(vld_b_v[1]), 1);
    chk("skid_lat_e2_data_b", 32'(data_b_v[1]), 'h5A);
    tick(); #1;
    chk("skid_lat_end_occ", get_occ(1), 0);

    // D4/S0: flush with three held words, then capacity limit
    rdy_b_v[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vld_a_v[2] = 1'b1; data_a_v[2] = 8'(8'hC1 + c);
      tick();
    end
    data_a_v[2] = 8'hF1; flush_v[2] = 1'b1;
    #1;
    chk("flush_rdy_a", 32'(rdy_a_v[2]), 0);
    chk("flush_vld_b", 32'(vld_b_v[2]), 0);
    chk("flush_pre_occ", get_occ(2), 3);
    tick();
    flush_v[2] = 1'b0; vld_a_v[2] = 1'b0; rdy_b_v[2] = 1'b1;
    #1;
    chk("flush_post_occ", get_occ(2), 0);
    chk("flush_post_vld_b", 32'(vld_b_v[2]), 0);
    for (int c = 0; c < 8; c++) begin
      tick(); #1;
      chk("flush_no_delivery", 32'(vld_b_v[2]), 0);
    end
    rdy_b_v[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      vld_a_v[2] = 1'b1; data_a_v[2] = 8'(8'hD0 + c);
      #1;
      tick();
    end
    vld_a_v[2] = 1'b0;
    #1;
    chk("cap_occ", get_occ(2), 4);
    chk("cap_rdy_a", 32'(rdy_a_v[2]), 0);
    chk("cap_vld_b", 32'(vld_b_v[2]), 1);
    chk("cap_data_b", 32'(data_b_v[2]), 'hD0);
    clear(2);

    // D2/S1 and D2/S0: streaming and random traffic against the scoreboard
    stream(3, 2);
    run_random(3, 2, 1'b1);
    run_random(0, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
